// File: rtl/anemo_pkg.sv
// Shared types and default parameters for the anemometer frequency meter.
// Latency: n/a (package). Backpressure: n/a.
package anemo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_WINDOW_CYC  = 50000000;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_CYC    = 4;

endpackage

// File: rtl/anemo_edge_sync.sv
// Synchronizes freq_in, optionally glitch-filters it (ANEMO_GLITCH_FILTER_EN), emits a one-cycle rising-edge pulse.
// Latency: SYNC_STAGES + 1 cycles from freq_in to edge_pulse (+FILT_CYC with the filter).
// Backpressure: none; free-running, every qualified edge produces one pulse.
module anemo_edge_sync
    import anemo_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef ANEMO_GLITCH_FILTER_EN
    ,
    parameter int FILT_CYC    = DEF_FILT_CYC
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic freq_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   det_lvl;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], freq_in};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef ANEMO_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

    logic             filt_q;
    logic [CNT_W-1:0] filt_cnt_q;

    // Level only flips after FILT_CYC consecutive samples disagreeing with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= '0;
        end else if (sync_lvl != filt_q) begin
            if (filt_cnt_q == CNT_LAST) begin
                filt_q     <= sync_lvl;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end else begin
            filt_cnt_q <= '0;
        end
    end

    assign det_lvl = filt_q;
`else
    assign det_lvl = sync_lvl;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            prev_q     <= det_lvl;
            edge_pulse <= det_lvl & ~prev_q;
        end
    end

endmodule

// File: rtl/anemo_freq_meter.sv
// Counts anemometer edges per WINDOW_CYC gate window, continuous or single-shot; ANEMO_GLITCH_FILTER_EN adds input filter.
// Latency: result and data_valid registered on the last window cycle edge; input path adds SYNC_STAGES+1 cycles.
// Backpressure: none; data_valid pulses (continuous) or holds until restart (single-shot), result holds between windows.
module anemo_freq_meter
    import anemo_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WINDOW_CYC  = DEF_WINDOW_CYC,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_CYC    = DEF_FILT_CYC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              freq_in,
    input  logic              continu,
    input  logic              start,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              overflow
);

    localparam int GATE_W = $clog2(WINDOW_CYC);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(WINDOW_CYC - 1);
    localparam logic [DATA_W-1:0] CNT_MAX   = '1;

    if (DATA_W < 4 || DATA_W > 16 || WINDOW_CYC < 2 || SYNC_STAGES < 2 || FILT_CYC < 1) begin : g_param_chk
        $error("anemo_freq_meter: parameter out of range");
    end

    state_t            state_q, state_nxt;
    logic              dv_nxt;
    logic              edge_pulse;
    logic              win_end;
    logic [GATE_W-1:0] gate_q;
    logic [DATA_W-1:0] edge_cnt_q, cnt_nxt;
    logic              win_ovf_q, ovf_nxt;

    anemo_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef ANEMO_GLITCH_FILTER_EN
        ,
        .FILT_CYC(FILT_CYC)
`endif
    ) u_edge_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .freq_in   (freq_in),
        .edge_pulse(edge_pulse)
    );

    // Saturating count; the final-cycle edge is folded in before the result is latched.
    always_comb begin
        win_end = (state_q == MEASURE) && (gate_q == GATE_LAST);
        cnt_nxt = edge_cnt_q;
        ovf_nxt = win_ovf_q;
        if (state_q == MEASURE && edge_pulse) begin
            if (edge_cnt_q == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = edge_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        dv_nxt    = data_valid;
        case (state_q)
            IDLE, DONE: begin
                if (continu || start) begin
                    state_nxt = MEASURE;
                    dv_nxt    = 1'b0;
                end
            end
            MEASURE: begin
                if (win_end) begin
                    dv_nxt    = 1'b1;
                    state_nxt = continu ? MEASURE : DONE;
                end else begin
                    dv_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                dv_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            data_valid <= 1'b0;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            win_ovf_q  <= 1'b0;
            data_out   <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            data_valid <= dv_nxt;
            if (win_end) begin
                gate_q     <= '0;
                edge_cnt_q <= '0;
                win_ovf_q  <= 1'b0;
                data_out   <= cnt_nxt;
                overflow   <= ovf_nxt;
            end else if (state_q == MEASURE) begin
                gate_q     <= gate_q + 1'b1;
                edge_cnt_q <= cnt_nxt;
                win_ovf_q  <= ovf_nxt;
            end
        end
    end

endmodule

// File: doc/anemo_freq_meter.md
ANEMO_FREQ_METER -- requirements
Module: anemo_freq_meter

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of measurement result (4..16).
REQ-002 SHALL have parameter WINDOW_CYC, default 50000000: gate window length in clk cycles (>=2).
REQ-003 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth (>=2).
REQ-004 SHALL have parameter FILT_CYC, default 4: glitch-filter stability length in clk cycles (>=1).
REQ-005 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port freq_in, input, 1: asynchronous anemometer pulse train.
REQ-008 SHALL have port continu, input, 1: 1 = continuous mode, 0 = single-shot mode.
REQ-009 SHALL have port start, input, 1: single-shot trigger, sampled high for one cycle.
REQ-010 SHALL have port data_out, output, DATA_W: edges counted in last completed window.
REQ-011 SHALL have port data_valid, output, 1: result-valid flag.
REQ-012 SHALL have port overflow, output, 1: last completed window saturated.

Function
REQ-013 SHALL pass freq_in through SYNC_STAGES flip-flops, then detect rising edges (one-cycle pulse per edge); edge pulse latency 1 cycle after last sync stage.
REQ-014 SHALL implement FSM states IDLE, MEASURE, DONE.
REQ-015 IDLE: continu=1 -> MEASURE next cycle; continu=0 and start=1 -> MEASURE next cycle, data_valid cleared same edge.
REQ-016 MEASURE: gate counter runs 0..WINDOW_CYC-1; edge counter increments per edge pulse.
REQ-017 Edge counter SHALL saturate at 2**DATA_W-1; any edge at saturation sets window-overflow flag.
REQ-018 An edge pulse in final window cycle SHALL be counted in ending window.
REQ-019 At window end: data_out <= edge count (including final-cycle edge), overflow <= window-overflow flag, counters cleared.
REQ-020 Window end with continu=1: stay MEASURE, new window starts next cycle without gap, data_valid high exactly one cycle.
REQ-021 Window end with continu=0: go DONE, data_valid high and held.
REQ-022 DONE: start=1 -> MEASURE, data_valid cleared; continu=1 -> MEASURE, data_valid cleared.
REQ-023 start SHALL be ignored in MEASURE; continu SHALL be sampled only in IDLE, DONE and at window end.
REQ-024 data_out and overflow SHALL hold between window ends.

Reset
REQ-025 reset_n low SHALL asynchronously force: FSM IDLE, counters 0, sync/filter stages 0, data_out 0, data_valid 0, overflow 0.
REQ-026 Reset during MEASURE SHALL discard the partial window; no data_valid produced.
REQ-027 Release SHALL be synchronous-safe: first FSM transition no earlier than first clk edge after deassertion.

Configuration
REQ-028 Macro ANEMO_GLITCH_FILTER_EN defined: synchronized input SHALL change filtered level only after FILT_CYC consecutive equal samples; edge detect uses filtered level (latency +FILT_CYC cycles).
REQ-029 Macro undefined: no filter logic; FILT_CYC unused; edge detect uses synchronized level directly.

Structure
REQ-030 Package anemo_pkg SHALL hold FSM state enum (IDLE, MEASURE, DONE) and default parameter constants.
REQ-031 Sub-module anemo_edge_sync SHALL contain synchronizer, optional glitch filter and edge detector, output one-cycle edge pulse.
REQ-032 Gate counter width SHALL be $clog2(WINDOW_CYC); no combinational path freq_in -> outputs.

Verification (DATA_W=8, WINDOW_CYC=100, SYNC_STAGES=2, FILT_CYC=4)
REQ-033 Continuous, freq_in period 10 cycles -> data_out=10, data_valid one-cycle pulse every 100 cycles.
REQ-034 Single-shot, start pulse, freq_in period 4 -> after 100 cycles data_out=25, data_valid held until next start.
REQ-035 DATA_W=4, freq_in period 4 (25 edges) -> data_out=15, overflow=1; next window period 10 -> data_out=10, overflow=0.
REQ-036 reset_n low at cycle 50 of MEASURE -> all outputs 0 immediately, no data_valid after release until new window completes.
REQ-037 With ANEMO_GLITCH_FILTER_EN, 2-cycle high glitches every 20 cycles -> data_out=0; without macro -> data_out=5.
REQ-038 Edge timed to final window cycle -> counted in ending window; start asserted mid-MEASURE -> ignored.
